// File: rtl/bcd_pkg.sv
// rtl/bcd_pkg.sv - shared FSM state and BCD digit constants for the BCD-to-binary converter
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int DIGIT_W    = 4;
  localparam int MAX_DIGIT  = 9;
  localparam int ADJ_THRESH = 8;
  localparam int ADJ_OFFSET = 3;

endpackage

// File: rtl/bcd_digit_adjust.sv
// rtl/bcd_digit_adjust.sv - per-digit reverse double-dabble correction (subtract 3 when >= 8)
module bcd_digit_adjust
  import bcd_pkg::*;
(
  input  logic [3:0] din,
  output logic [3:0] dout
);

  assign dout = (din >= 4'(ADJ_THRESH)) ? (din - 4'(ADJ_OFFSET)) : din;

endmodule

// File: rtl/bcd_to_binary.sv
// rtl/bcd_to_binary.sv - sequential packed-BCD to binary converter, one shift step per clock
module bcd_to_binary
  import bcd_pkg::*;
#(
  parameter int DIGITS = 3,
  parameter int BIN_W  = 10
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [4*DIGITS-1:0]   in_bcd,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [BIN_W-1:0]      out_bin,
  output logic                  out_err,
  output logic                  out_valid,
  input  logic                  out_ready
);

  localparam int W     = 4*DIGITS + BIN_W;
  localparam int CNT_W = $clog2(BIN_W + 1);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [W-1:0]     work;
  logic [W-1:0]     shifted;
  logic [W-1:0]     stepped;
  logic             bad_digit;

  // Working register: BCD digits on top, binary result accumulates from the top of the low field.
  assign shifted = work >> 1;
  assign stepped[BIN_W-1:0] = shifted[BIN_W-1:0];

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_digit_adjust u_adj (
      .din  (shifted[BIN_W + DIGIT_W*g +: DIGIT_W]),
      .dout (stepped[BIN_W + DIGIT_W*g +: DIGIT_W])
    );
  end

  always_comb begin
    bad_digit = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (in_bcd[DIGIT_W*i +: DIGIT_W] > 4'(MAX_DIGIT)) bad_digit = 1'b1;
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DONE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      cnt     <= '0;
      work    <= '0;
      out_bin <= '0;
      out_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            work <= {in_bcd, {BIN_W{1'b0}}};
            cnt  <= '0;
            if (bad_digit) begin
              state   <= DONE;
              out_bin <= '0;
              out_err <= 1'b1;
            end else begin
              state <= SHIFT;
            end
          end
        end
        SHIFT: begin
          work <= stepped;
          cnt  <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(BIN_W - 1)) begin
            state   <= DONE;
            out_bin <= stepped[BIN_W-1:0];
            out_err <= 1'b0;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_bcd_to_binary.sv
// tb/tb_bcd_to_binary.sv - self-checking bench for bcd_to_binary with an arithmetic reference model
module tb_bcd_to_binary;

  localparam int DIGITS = 3;
  localparam int BIN_W  = 10;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [11:0]      in_bcd = '0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [BIN_W-1:0] out_bin;
  logic             out_err;
  logic             out_valid;
  logic             out_ready = 1'b0;

  int n_tests = 0;
  int n_fail = 0;
  int n_results = 0;

  bcd_to_binary #(.DIGITS(DIGITS), .BIN_W(BIN_W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_bcd    (in_bcd),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_bin   (out_bin),
    .out_err   (out_err),
    .out_valid (out_valid),
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int bcd_val(input logic [11:0] b);
    logic [11:0] v;
    v = b;
    return int'(v[3:0]) + 10*int'(v[7:4]) + 100*int'(v[11:8]);
  endfunction

  function automatic bit bcd_bad(input logic [11:0] b);
    logic [11:0] v;
    v = b;
    return (v[3:0] > 9) || (v[7:4] > 9) || (v[11:8] > 9);
  endfunction

  // Reference model: a result appears BIN_W edges after a good accept, right after a bad one.
  bit m_busy, m_hold, m_err;
  int m_left, m_bin;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_busy <= 0; m_hold <= 0; m_err <= 0; m_left <= 0; m_bin <= 0;
    end else if (m_hold) begin
      if (out_ready) m_hold <= 0;
    end else if (m_busy) begin
      if (m_left == 1) begin
        m_busy <= 0;
        m_hold <= 1;
      end
      m_left <= m_left - 1;
    end else if (in_valid) begin
      if (bcd_bad(in_bcd)) begin
        m_hold <= 1; m_err <= 1; m_bin <= 0;
      end else begin
        m_busy <= 1; m_left <= BIN_W; m_err <= 0; m_bin <= bcd_val(in_bcd);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", int'(in_ready), int'(!(m_busy || m_hold)));
      check("out_valid", int'(out_valid), int'(m_hold));
      if (m_hold) begin
        check("out_bin", int'(out_bin), m_bin);
        check("out_err", int'(out_err), int'(m_err));
      end
    end
  end

  always @(posedge clk) begin
    if (rst_n && out_valid && out_ready) n_results++;
  end

  // exp_lat counts edges after the accept edge until out_valid is visible.
  task automatic convert(input logic [11:0] bcd, input int hold, input int exp_bin,
                         input logic exp_err, input int exp_lat,
                         input bit pulse_en, input logic [11:0] pulse);
    int lat;
    int saved;
    @(negedge clk); #1;
    in_bcd = bcd; in_valid = 1'b1; out_ready = (hold == 0);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 50) begin
      in_valid = pulse_en && (lat == 2);
      in_bcd   = (pulse_en && lat == 2) ? pulse : bcd;
      @(posedge clk); #1;
      lat++;
    end
    in_valid = 1'b0;
    check("result_seen", int'(out_valid), 1);
    check("latency", lat, exp_lat);
    check("lit_bin", int'(out_bin), exp_bin);
    check("lit_err", int'(out_err), int'(exp_err));
    check("model_bin", m_bin, exp_bin);
    saved = int'(out_bin);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_valid", int'(out_valid), 1);
      check("hold_bin", int'(out_bin), saved);
      check("hold_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("post_in_ready", int'(in_ready), 1);
    check("post_out_valid", int'(out_valid), 0);
  endtask

  initial begin
    #2;
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_out_bin", int'(out_bin), 0);
    check("rst_out_err", int'(out_err), 0);
    #21 rst_n = 1'b1;

    convert(12'h255, 0, 255, 1'b0, 10, 1'b0, 12'h000);
    convert(12'h999, 0, 999, 1'b0, 10, 1'b0, 12'h000);
    convert(12'h000, 0,   0, 1'b0, 10, 1'b0, 12'h000);
    convert(12'h1A3, 0,   0, 1'b1,  0, 1'b0, 12'h000);
    convert(12'h128, 5, 128, 1'b0, 10, 1'b0, 12'h000);
    convert(12'h042, 0,  42, 1'b0, 10, 1'b1, 12'h300);
    convert(12'hF00, 2,   0, 1'b1,  0, 1'b0, 12'h000);

    // Abandon a conversion with reset partway through the shift phase.
    @(negedge clk); #1;
    in_bcd = 12'h064; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("midrst_in_ready", int'(in_ready), 1);
    check("midrst_out_valid", int'(out_valid), 0);
    check("midrst_out_bin", int'(out_bin), 0);
    #1 rst_n = 1'b1;
    n_results = 0;
    repeat (15) @(posedge clk);
    #1;
    check("no_stale_result", n_results, 0);
    convert(12'h007, 0, 7, 1'b0, 10, 1'b0, 12'h000);
    check("one_result", n_results, 1);

    repeat (3) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1);
  end

endmodule
